// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data load/store unit.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents: access-size and FSM-state enums, byte-enable generator.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10,
    LSU_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } lsu_state_e;

  // Byte lanes touched by an access; illegal size touches none.
  function automatic logic [3:0] be_gen(input lsu_size_e size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      LSU_BYTE: be = 4'b0001 << addr_lo;
      LSU_HALF: be = 4'b0011 << addr_lo;
      LSU_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_align.sv
// Load-side extraction: picks byte/half/word out of a RAM word and extends it.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   ram_rdata_i  32-bit word read from RAM
//   addr_lo_i    byte offset within the word
//   size_i       access size (lsu_size_e encoding)
//   unsigned_i   1=zero-extend, 0=sign-extend (byte/half only)
//   result_o     right-aligned, extended load value
module data_align
  import lsu_pkg::*;
(
  input  logic [31:0] ram_rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  // Move the addressed byte lane down to bit 0 before masking.
  assign shifted = ram_rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    result_o = 32'h0;
    case (size_i)
      LSU_BYTE: result_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      LSU_HALF: result_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      LSU_WORD: result_o = shifted;
      default:  result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit: one request at a time between execute stage and 32-bit data RAM.
// Latency: accept -> RAM drive next cycle -> response pulse the cycle after (3-cycle turnaround).
// Backpressure: ready_o low for two cycles after acceptance; requests seen then are ignored.
//
// Ports:
//   clk_i, rstn_i                  clock, synchronous active-low reset
//   req_i/we_i/size_i/unsigned_i   request: valid, store flag, size, zero-extend
//   addr_i/wdata_i                 byte address, right-aligned store data
//   ready_o                        request accepted this cycle when high
//   rvalid_o/rdata_o               response pulse and load result
//   misaligned_o/err_o             fault / RAM error, qualified by rvalid_o
//   ram_we/ram_be/ram_addr/ram_wdata  RAM master drive (only during ISSUE)
//   ram_rdata/ram_err              RAM read data and error, valid in RESP
module data_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  misaligned_o,
  output logic                  err_o,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_err
);

  lsu_state_e            state_q;
  logic                  ready_q;
  logic                  rvalid_q;
  logic                  we_q;
  lsu_size_e             size_q;
  logic                  unsigned_q;
  logic [1:0]            addr_lo_q;
  logic                  fault_q;
  logic                  ram_we_q;
  logic [3:0]            ram_be_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [31:0]           ram_wdata_q;

  // Request-side decode, evaluated on the incoming request.
  lsu_size_e             req_size;
  logic                  fault_d;
  logic [3:0]            ram_be_d;
  logic [31:0]           ram_wdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;

  assign req_size   = lsu_size_e'(size_i);
  assign ram_addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    fault_d = 1'b0;
    case (req_size)
      LSU_HALF: fault_d = addr_i[0];
      LSU_WORD: fault_d = (addr_i[1:0] != 2'b00);
      LSU_ILL:  fault_d = 1'b1;
      default:  fault_d = 1'b0;
    endcase
  end

  // A faulted access keeps the bus idle: no lanes enabled, no write.
  assign ram_be_d = fault_d ? 4'b0000 : be_gen(req_size, addr_i[1:0]);

  always_comb begin
    ram_wdata_d = 32'h0;
    if (we_i) begin
      case (req_size)
        LSU_BYTE: ram_wdata_d = {4{wdata_i[7:0]}};
        LSU_HALF: ram_wdata_d = {2{wdata_i[15:0]}};
        LSU_WORD: ram_wdata_d = wdata_i;
        default:  ram_wdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rvalid_q    <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= LSU_BYTE;
      unsigned_q  <= 1'b0;
      addr_lo_q   <= 2'b00;
      fault_q     <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            state_q     <= ISSUE;
            ready_q     <= 1'b0;
            we_q        <= we_i;
            size_q      <= req_size;
            unsigned_q  <= unsigned_i;
            addr_lo_q   <= addr_i[1:0];
            fault_q     <= fault_d;
            ram_we_q    <= we_i & ~fault_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
          end
        end
        ISSUE: begin
          // RAM drive lasts exactly one cycle; bus returns to zero in RESP.
          state_q     <= RESP;
          rvalid_q    <= 1'b1;
          ram_we_q    <= 1'b0;
          ram_be_q    <= 4'b0000;
          ram_addr_q  <= '0;
          ram_wdata_q <= 32'h0;
        end
        RESP: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  logic [31:0] load_result;

  data_align u_align (
    .ram_rdata_i (ram_rdata),
    .addr_lo_i   (addr_lo_q),
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .result_o    (load_result)
  );

  // Response fields are qualified by rvalid so they read zero outside RESP.
  assign ready_o      = ready_q;
  assign rvalid_o     = rvalid_q;
  assign misaligned_o = rvalid_q & fault_q;
  assign err_o        = rvalid_q & ~fault_q & ram_err;
  assign rdata_o      = (rvalid_q && !fault_q && !we_q) ? load_result : 32'h0;

  assign ram_we    = ram_we_q;
  assign ram_be    = ram_be_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_data_lsu.sv
// Directed bench for data_lsu: store/load formatting, faults, throughput, reset abort.
module tb_data_lsu;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        misaligned_o;
  logic        err_o;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_err;

  int tests = 0;
  int fails = 0;

  data_lsu #(.ADDR_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .size_i       (size_i),
    .unsigned_i   (unsigned_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ready_o      (ready_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .err_o        (err_o),
    .ram_we       (ram_we),
    .ram_be       (ram_be),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_err      (ram_err)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE, clock it in, drop req; leaves the DUT in ISSUE.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
    tick();
    req_i = 1'b0;
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, ".ram_we"},    {31'h0, ram_we}, 32'h0);
    chk({tag, ".ram_be"},    {28'h0, ram_be}, 32'h0);
    chk({tag, ".ram_addr"},  ram_addr,        32'h0);
    chk({tag, ".ram_wdata"}, ram_wdata,       32'h0);
  endtask

  int acc;
  int rv_cnt;
  logic [5:0] rdy_pat;
  logic [5:0] rv_pat;

  initial begin
    rstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; ram_rdata = 32'h0; ram_err = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst.ready",  {31'h0, ready_o},      32'h1);
    chk("rst.rvalid", {31'h0, rvalid_o},     32'h0);
    chk("rst.rdata",  rdata_o,               32'h0);
    chk("rst.mis",    {31'h0, misaligned_o}, 32'h0);
    chk("rst.err",    {31'h0, err_o},        32'h0);
    chk_bus_idle("rst");
    rstn_i = 1'b1;
    tick();

    // Store byte 0xA5 to 0x1003
    issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    chk("sb.ready",  {31'h0, ready_o}, 32'h0);
    chk("sb.we",     {31'h0, ram_we},  32'h1);
    chk("sb.be",     {28'h0, ram_be},  32'h8);
    chk("sb.addr",   ram_addr,         32'h0000_1000);
    chk("sb.wdata",  ram_wdata,        32'hA5A5_A5A5);
    ram_rdata = 32'hDEAD_BEEF; ram_err = 1'b0;
    tick();
    chk("sb.rvalid", {31'h0, rvalid_o}, 32'h1);
    chk("sb.rdata",  rdata_o,           32'h0);
    chk("sb.mis",    {31'h0, misaligned_o}, 32'h0);
    chk_bus_idle("sb.resp");
    tick();
    chk("sb.ready_back", {31'h0, ready_o},  32'h1);
    chk("sb.rvalid_off", {31'h0, rvalid_o}, 32'h0);

    // Signed half load from 0x102
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'hFFFF_FFFF);
    chk("lh.we",    {31'h0, ram_we}, 32'h0);
    chk("lh.be",    {28'h0, ram_be}, 32'hC);
    chk("lh.addr",  ram_addr,        32'h0000_0100);
    chk("lh.wdata", ram_wdata,       32'h0);
    ram_rdata = 32'h8001_1234;
    tick();
    chk("lh.rdata", rdata_o, 32'hFFFF_8001);
    chk("lh.err",   {31'h0, err_o}, 32'h0);
    tick();

    // Unsigned half load from 0x102
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
    tick();
    chk("lhu.rdata", rdata_o, 32'h0000_8001);
    tick();

    // Signed byte load from 0x101
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0);
    chk("lb1.be", {28'h0, ram_be}, 32'h2);
    tick();
    chk("lb1.rdata", rdata_o, 32'h0000_0012);
    tick();

    // Signed byte load from 0x103 (negative byte 0x80)
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
    tick();
    chk("lb3.rdata", rdata_o, 32'hFFFF_FF80);
    tick();

    // Aligned word load, unsigned flag must not matter
    issue(1'b0, 2'b10, 1'b1, 32'h0000_0104, 32'h0);
    chk("lw.be", {28'h0, ram_be}, 32'hF);
    tick();
    chk("lw.rdata", rdata_o, 32'h8001_1234);
    tick();

    // Misaligned word load from 0x6; RAM error must be ignored
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    chk("mw.we", {31'h0, ram_we}, 32'h0);
    chk("mw.be", {28'h0, ram_be}, 32'h0);
    ram_err = 1'b1;
    tick();
    chk("mw.rvalid", {31'h0, rvalid_o},     32'h1);
    chk("mw.mis",    {31'h0, misaligned_o}, 32'h1);
    chk("mw.err",    {31'h0, err_o},        32'h0);
    chk("mw.rdata",  rdata_o,               32'h0);
    ram_err = 1'b0;
    tick();

    // Illegal size at an aligned address
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'h1234_5678);
    chk("ill.we", {31'h0, ram_we}, 32'h0);
    chk("ill.be", {28'h0, ram_be}, 32'h0);
    tick();
    chk("ill.mis",   {31'h0, misaligned_o}, 32'h1);
    chk("ill.err",   {31'h0, err_o},        32'h0);
    chk("ill.rdata", rdata_o,               32'h0);
    tick();

    // Misaligned half store: no write, flagged
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_BEEF);
    chk("mh.we", {31'h0, ram_we}, 32'h0);
    tick();
    chk("mh.mis", {31'h0, misaligned_o}, 32'h1);
    tick();

    // Half store at 0x22
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_BEEF);
    chk("sh.we",    {31'h0, ram_we}, 32'h1);
    chk("sh.be",    {28'h0, ram_be}, 32'hC);
    chk("sh.addr",  ram_addr,        32'h0000_0020);
    chk("sh.wdata", ram_wdata,       32'hBEEF_BEEF);
    tick();
    tick();

    // Word store with RAM error, then a load at the first ready cycle
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D);
    chk("swe.wdata", ram_wdata, 32'hCAFE_F00D);
    ram_err = 1'b1;
    tick();
    chk("swe.err",   {31'h0, err_o},        32'h1);
    chk("swe.mis",   {31'h0, misaligned_o}, 32'h0);
    chk("swe.rdata", rdata_o,               32'h0);
    ram_err = 1'b0;
    tick();
    chk("swe.ready", {31'h0, ready_o}, 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    ram_rdata = 32'h0BAD_CAFE;
    tick();
    chk("lwe.err",   {31'h0, err_o}, 32'h0);
    chk("lwe.rdata", rdata_o,        32'h0BAD_CAFE);
    tick();

    // req_i held high for 6 cycles: accept at cycles 0 and 3
    rdy_pat = 6'b001001;
    rv_pat  = 6'b100100;
    acc = 0;
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h0000_0080;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("tp.ready%0d", c),  {31'h0, ready_o},  {31'h0, rdy_pat[c]});
      chk($sformatf("tp.rvalid%0d", c), {31'h0, rvalid_o}, {31'h0, rv_pat[c]});
      if (ready_o && req_i) acc++;
      tick();
    end
    req_i = 1'b0;
    chk("tp.accepts", acc, 32'd2);

    // Reset asserted during ISSUE of a load
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    chk("ra.ready",  {31'h0, ready_o},  32'h1);
    chk("ra.rvalid", {31'h0, rvalid_o}, 32'h0);
    chk_bus_idle("ra");
    rv_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (rvalid_o) rv_cnt++;
      tick();
    end
    chk("ra.no_rvalid", rv_cnt, 32'd0);

    // Reset together with a request: not accepted
    rstn_i = 1'b0; req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 32'h0000_0200;
    wdata_i = 32'h1111_2222;
    tick();
    rstn_i = 1'b1; req_i = 1'b0;
    chk("rr.ready", {31'h0, ready_o}, 32'h1);
    chk("rr.we",    {31'h0, ram_we},  32'h0);
    tick();
    chk("rr.rvalid", {31'h0, rvalid_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_lsu.md
# data_lsu

Load/store unit between the core's execute stage and the 32-bit data RAM port. It accepts one load or store request at a time and drives the master side of the `if_ram_2way_32b_data` interface (`ram_we`, `ram_be`, `ram_addr`, `ram_wdata`; reads back `ram_rdata` and `ram_err`). For stores it generates byte enables and replicated write data. For loads it extracts, sign-extends or zero-extends the addressed byte, halfword or word. It flags misaligned and illegal-size accesses without touching the RAM.

## Interface
- ADDR_WIDTH, 32, byte-address width; must match the RAM interface instance.
- clk_i  in  1  single clock; all state updates on rising edge.
- rstn_i  in  1  reset; synchronous, active-low.
- req_i  in  1  request valid; sampled only while ready_o=1.
- we_i  in  1  1=store, 0=load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_i  in  1  loads only: 1=zero-extend, 0=sign-extend.
- addr_i  in  ADDR_WIDTH  byte address.
- wdata_i  in  32  store data, right-aligned.
- ready_o  out  1  accepts a request this cycle.
- rvalid_o  out  1  one-cycle response pulse.
- rdata_o  out  32  load result; 0 for stores and faults.
- misaligned_o  out  1  valid with rvalid_o: misaligned or illegal size.
- err_o  out  1  valid with rvalid_o: RAM reported error.
- ram_we  out  1  RAM write enable (MASTER modport).
- ram_be  out  4  RAM byte enables.
- ram_addr  out  ADDR_WIDTH  RAM word address (bits [1:0]=0).
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after issue.
- ram_err  in  1  RAM error, valid with ram_rdata.

## Operation
- FSM states IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: ready_o=1. If req_i=1, latch we, size, unsigned, addr[1:0] and the fault flag, register the RAM drive values, and go to ISSUE.
- ISSUE: ready_o=0. ram_* outputs hold the registered values for exactly this cycle. Go to RESP unconditionally.
- RESP: ready_o=0, rvalid_o=1. Go to IDLE.
- Fault conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - size 11.
- A faulted access still passes through ISSUE, but with ram_we=0 and ram_be=0000. In RESP it gives misaligned_o=1, err_o=0, rdata_o=0, and ram_err is ignored.
- ram_addr = {addr_i[ADDR_WIDTH-1:2], 2'b00}.
- ram_be:
  - byte: 0001<<addr[1:0];
  - half: 0011<<addr[1:0];
  - word: 1111.
  - Loads drive the same ram_be as stores.
- ram_wdata:
  - byte: {4{wdata_i[7:0]}};
  - half: {2{wdata_i[15:0]}};
  - word: wdata_i.
  - Loads drive ram_wdata=0.
- ram_we=1 only in ISSUE, for a non-faulted store.
- Load result: shift ram_rdata right by 8·addr[1:0], then mask to the access size and extend per unsigned_i. Computed combinationally in RESP. Word loads ignore unsigned_i.
- Store response: rdata_o=0, err_o=ram_err.
- Non-faulted load: err_o=ram_err, and rdata_o is still driven.
- req_i while ready_o=0 is ignored. There is no queueing; upstream holds the request until ready_o=1.

## Timing
- Request accepted at edge E0 (IDLE, req_i=1).
- ISSUE is cycle E0→E1, RESP is cycle E1→E2. rvalid_o is high during E1→E2.
- ready_o returns to 1 during E2→E3.
- Throughput: one access per 3 cycles. Load-use latency: 2 cycles after acceptance.
- Outside ISSUE: ram_we=0, ram_be=0000, ram_addr=0, ram_wdata=0.
- Reset values: state IDLE, ready_o=1, rvalid_o=0, rdata_o=0, misaligned_o=0, err_o=0, all ram_* outputs 0.
- rstn_i=0 in ISSUE or RESP: the next cycle is IDLE with all outputs at reset values. The pending operation is dropped and no rvalid_o is issued. A store already driven in ISSUE may have committed.
- rstn_i=0 together with req_i=1: the request is not accepted.

## Structure
- Package lsu_pkg holds:
  - enum lsu_size_e (LSU_BYTE=2'b00, LSU_HALF=2'b01, LSU_WORD=2'b10, LSU_ILL=2'b11);
  - enum lsu_state_e (IDLE, ISSUE, RESP).
  - Function be_gen(size, addr_lo) returning 4 bits.
- Sub-module data_align: combinational load extraction.
  - Inputs: ram_rdata, addr_lo[1:0], size, unsigned.
  - Output: 32-bit result.
  - Reused by a future RAM slave model in the bench.
- Top data_lsu holds the FSM, request registers, store-side formatting and the response muxing.

## Test plan
- Store byte 0xA5 to 0x0000_1003 → ISSUE: ram_we=1, ram_be=1000, ram_addr=0x0000_1000, ram_wdata=0xA5A5_A5A5; RESP: rvalid_o=1, rdata_o=0.
- Signed half load from 0x102 with ram_rdata=0x8001_1234 → rdata_o=0xFFFF_8001. Unsigned: 0x0000_8001. Signed byte from 0x101, same data: 0x0000_0012.
- Word load from 0x0000_0006 → ISSUE: ram_be=0000, ram_we=0; RESP: misaligned_o=1, err_o=0, rdata_o=0. Same result for size=11 at an aligned address.
- Word store with ram_err=1 in RESP → err_o=1, misaligned_o=0. A following load accepted at the first ready_o cycle has ram_err=0 → err_o=0.
- req_i held high for 6 cycles with loads → exactly 2 acceptances 3 cycles apart. ready_o pattern 1,0,0,1,0,0. rvalid_o pulses at cycles 2 and 5.
- rstn_i low during ISSUE of a load → rvalid_o never asserts. The next cycle shows ready_o=1 and all ram_* outputs 0.
